vga_rect_fill: RTL and testbench

Hardware rectangle-fill engine for the 80x60 VGA framebuffer. It is a memory-mapped IOBUS peripheral that sits between the MCU's IOBUS and the framebuffer write port (WA/WD/WE). It accepts a rectangle (origin, size, colour) from software, clips it to the screen, and writes one pixel per clock in raster order. Its purpose is to offload paddle, ball and score-area redraws from the CPU.

---
 rtl/vga_rect_pkg.sv | 37 +++
 rtl/vga_rect_clip.sv | 41 ++++
 rtl/vga_rect_fill.sv | 218 +++++++++++++++++++++
 tb/tb_vga_rect_fill.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rect_pkg.sv
// Shared definitions for the vga_rect rectangle-fill engine: IOBUS register map,
// framebuffer geometry defaults, FSM state encoding and the framebuffer cursor type.
package vga_rect_pkg;

  localparam logic [31:0] RECT_XY_AD   = 32'h1120_0000;
  localparam logic [31:0] RECT_WH_AD   = 32'h1124_0000;
  localparam logic [31:0] RECT_GO_AD   = 32'h1128_0000;
  localparam logic [31:0] RECT_STAT_AD = 32'h112C_0000;

  localparam int unsigned FB_W_DEF = 80;
  localparam int unsigned FB_H_DEF = 60;

  localparam int unsigned X_W   = 7;
  localparam int unsigned Y_W   = 6;
  localparam int unsigned WA_W  = X_W + Y_W;
  localparam int unsigned COL_W = 8;
  localparam int unsigned BUS_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Packed so that a cursor is bit-for-bit the framebuffer address {y, x}.
  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } cursor_t;

  function automatic cursor_t mk_cursor(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    cursor_t c;
    c.x = x;
    c.y = y;
    return c;
  endfunction

endpackage

// File: rtl/vga_rect_clip.sv
// Combinational clipper: turns origin/size into inclusive end coordinates clipped
// to the framebuffer, flagging off-screen origins, empty rectangles and clipping.
module vga_rect_clip
  import vga_rect_pkg::*;
#(
  parameter int unsigned FB_W = FB_W_DEF,
  parameter int unsigned FB_H = FB_H_DEF
) (
  input  logic [X_W-1:0] x0_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [X_W-1:0] w_i,
  input  logic [Y_W-1:0] h_i,
  output logic [X_W-1:0] xe_o,
  output logic [Y_W-1:0] ye_o,
  output logic           clip_o,
  output logic           reject_o,
  output logic           empty_o
);

  // One extra bit on each sum so origin + size can never wrap.
  localparam int unsigned SX_W = X_W + 1;
  localparam int unsigned SY_W = Y_W + 1;

  logic [SX_W-1:0] sum_x;
  logic [SY_W-1:0] sum_y;
  logic            clip_x;
  logic            clip_y;

  always_comb begin
    sum_x    = SX_W'(x0_i) + SX_W'(w_i);
    sum_y    = SY_W'(y0_i) + SY_W'(h_i);
    clip_x   = (sum_x > SX_W'(FB_W));
    clip_y   = (sum_y > SY_W'(FB_H));
    xe_o     = clip_x ? X_W'(FB_W - 1) : X_W'(sum_x - SX_W'(1));
    ye_o     = clip_y ? Y_W'(FB_H - 1) : Y_W'(sum_y - SY_W'(1));
    clip_o   = clip_x || clip_y;
    reject_o = (SX_W'(x0_i) >= SX_W'(FB_W)) || (SY_W'(y0_i) >= SY_W'(FB_H));
    empty_o  = (w_i == '0) || (h_i == '0);
  end

endmodule

// File: rtl/vga_rect_fill.sv
// IOBUS rectangle-fill engine for the 80x60 framebuffer: one pixel per clock in raster order.
// Define VGA_RECT_OUTLINE_EN to add outline mode (GO data bit 8) that writes only the perimeter.
module vga_rect_fill
  import vga_rect_pkg::*;
#(
  parameter int unsigned FB_W = FB_W_DEF,
  parameter int unsigned FB_H = FB_H_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [BUS_W-1:0]  IOBUS_ADDR,
  input  logic [BUS_W-1:0]  IOBUS_OUT,
  input  logic              IOBUS_WR,
  output logic [BUS_W-1:0]  RD_DATA,
  output logic [WA_W-1:0]   FB_WA,
  output logic [COL_W-1:0]  FB_WD,
  output logic              FB_WE,
  output logic              BUSY,
  output logic              DONE
);

  state_e           state_q, state_d;
  cursor_t          cur_q, cur_d;
  cursor_t          start_q, start_d;
  cursor_t          end_q, end_d;
  logic [COL_W-1:0] color_q, color_d;
  logic [X_W-1:0]   x0_sh_q, x0_sh_d;
  logic [Y_W-1:0]   y0_sh_q, y0_sh_d;
  logic [X_W-1:0]   w_sh_q, w_sh_d;
  logic [Y_W-1:0]   h_sh_q, h_sh_d;
  logic             clip_q, clip_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             fb_we_q, fb_we_d;
  cursor_t          fb_wa_q, fb_wa_d;
  logic [COL_W-1:0] fb_wd_q, fb_wd_d;

  logic wr_xy, wr_wh, wr_go, wr_stat;
  logic launch_c;
  logic jump_c;

  logic [X_W-1:0] clip_xe;
  logic [Y_W-1:0] clip_ye;
  logic           clip_hit, clip_reject, clip_empty;

  logic unused_bus_bits;
  assign unused_bus_bits = ^IOBUS_OUT[BUS_W-1:14];

  assign wr_xy   = IOBUS_WR && (IOBUS_ADDR == RECT_XY_AD);
  assign wr_wh   = IOBUS_WR && (IOBUS_ADDR == RECT_WH_AD);
  assign wr_go   = IOBUS_WR && (IOBUS_ADDR == RECT_GO_AD);
  assign wr_stat = IOBUS_WR && (IOBUS_ADDR == RECT_STAT_AD);

  assign launch_c = wr_go && (state_q == IDLE) && !clip_reject && !clip_empty;

  vga_rect_clip #(
    .FB_W (FB_W),
    .FB_H (FB_H)
  ) u_clip (
    .x0_i     (x0_sh_q),
    .y0_i     (y0_sh_q),
    .w_i      (w_sh_q),
    .h_i      (h_sh_q),
    .xe_o     (clip_xe),
    .ye_o     (clip_ye),
    .clip_o   (clip_hit),
    .reject_o (clip_reject),
    .empty_o  (clip_empty)
  );

`ifdef VGA_RECT_OUTLINE_EN
  logic outline_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      outline_q <= 1'b0;
    end else if (launch_c) begin
      outline_q <= IOBUS_OUT[8];
    end
  end

  // Interior rows of an outline skip straight from the left edge to the right edge.
  assign jump_c = outline_q && (cur_q.x == start_q.x) &&
                  (cur_q.y != start_q.y) && (cur_q.y != end_q.y);
`else
  assign jump_c = 1'b0;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    start_d = start_q;
    end_d   = end_q;
    color_d = color_q;
    x0_sh_d = x0_sh_q;
    y0_sh_d = y0_sh_q;
    w_sh_d  = w_sh_q;
    h_sh_d  = h_sh_q;
    clip_d  = clip_q;
    ovr_d   = ovr_q;
    fb_we_d = 1'b0;
    fb_wa_d = fb_wa_q;
    fb_wd_d = fb_wd_q;
    busy_d  = (state_q == FILL);
    last_d  = 1'b0;
    done_d  = last_q;

    if (wr_xy) begin
      x0_sh_d = IOBUS_OUT[6:0];
      y0_sh_d = IOBUS_OUT[13:8];
    end
    if (wr_wh) begin
      w_sh_d = IOBUS_OUT[6:0];
      h_sh_d = IOBUS_OUT[13:8];
    end
    if (wr_stat) begin
      clip_d = 1'b0;
      ovr_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (wr_go) begin
          if (clip_reject) begin
            clip_d = 1'b1;
          end else if (clip_empty) begin
            last_d = 1'b1;
          end else begin
            if (clip_hit) begin
              clip_d = 1'b1;
            end
            start_d = mk_cursor(x0_sh_q, y0_sh_q);
            end_d   = mk_cursor(clip_xe, clip_ye);
            cur_d   = mk_cursor(x0_sh_q, y0_sh_q);
            color_d = IOBUS_OUT[7:0];
            state_d = FILL;
          end
        end
      end

      FILL: begin
        fb_we_d = 1'b1;
        fb_wa_d = cur_q;
        fb_wd_d = color_q;
        if (wr_go) begin
          ovr_d = 1'b1;
        end
        if (cur_q.x == end_q.x) begin
          if (cur_q.y == end_q.y) begin
            state_d = IDLE;
            last_d  = 1'b1;
          end else begin
            cur_d.x = start_q.x;
            cur_d.y = cur_q.y + Y_W'(1);
          end
        end else if (jump_c) begin
          cur_d.x = end_q.x;
        end else begin
          cur_d.x = cur_q.x + X_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cur_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      color_q <= '0;
      x0_sh_q <= '0;
      y0_sh_q <= '0;
      w_sh_q  <= '0;
      h_sh_q  <= '0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      fb_we_q <= 1'b0;
      fb_wa_q <= '0;
      fb_wd_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      start_q <= start_d;
      end_q   <= end_d;
      color_q <= color_d;
      x0_sh_q <= x0_sh_d;
      y0_sh_q <= y0_sh_d;
      w_sh_q  <= w_sh_d;
      h_sh_q  <= h_sh_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      done_q  <= done_d;
      fb_we_q <= fb_we_d;
      fb_wa_q <= fb_wa_d;
      fb_wd_q <= fb_wd_d;
    end
  end

  assign RD_DATA = (IOBUS_ADDR == RECT_STAT_AD) ? {29'd0, ovr_q, clip_q, busy_q} : '0;
  assign FB_WA   = fb_wa_q;
  assign FB_WD   = fb_wd_q;
  assign FB_WE   = fb_we_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: table of rectangles checked against a pixel
// scoreboard, plus overrun and mid-fill reset sequences; outline cases when VGA_RECT_OUTLINE_EN is set.
module tb_vga_rect_fill;

  localparam logic [31:0] XY_AD   = 32'h1120_0000;
  localparam logic [31:0] WH_AD   = 32'h1124_0000;
  localparam logic [31:0] GO_AD   = 32'h1128_0000;
  localparam logic [31:0] STAT_AD = 32'h112C_0000;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic [12:0] FB_WA;
  logic [7:0]  FB_WD;
  logic        FB_WE;
  logic        BUSY;
  logic        DONE;

  vga_rect_fill dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RD_DATA    (RD_DATA),
    .FB_WA      (FB_WA),
    .FB_WD      (FB_WD),
    .FB_WE      (FB_WE),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    int x0; int y0; int w; int h; int col; bit outl;
    int npix; int done; int stat;
  } vec_t;

  vec_t vecs[$];
  int   exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  int   first_cyc = -1;
  int   last_cyc = -1;
  int   done_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; samples DUT outputs on the falling edge and scores framebuffer writes.
  task automatic tick();
    int e;
    int a;
    @(negedge CLK);
    cyc++;
    if (RESET_N && FB_WE) begin
      wr_cnt++;
      a = int'({FB_WA, FB_WD});
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got 0x%0h, expected no write (cycle %0d)", a, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pixel", a, e);
      end
    end
    if (RESET_N && DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic io_wr(input logic [31:0] addr, input int data);
    tick();
    IOBUS_ADDR = addr;
    IOBUS_OUT  = 32'(data);
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
  endtask

  task automatic rd_stat(input string name, input int exp);
    tick();
    IOBUS_ADDR = STAT_AD;
    #1;
    check(name, int'(RD_DATA), exp);
    IOBUS_ADDR = '0;
  endtask

  // Reference model: pushes every expected {addr, colour} in raster order.
  task automatic model(input int x0, input int y0, input int w, input int h,
                       input int col, input bit outl);
    int xe;
    int ye;
    if (x0 >= 80 || y0 >= 60 || w == 0 || h == 0) return;
    xe = (x0 + w > 80) ? 79 : x0 + w - 1;
    ye = (y0 + h > 60) ? 59 : y0 + h - 1;
    for (int y = y0; y <= ye; y++)
      for (int x = x0; x <= xe; x++)
        if (!outl || y == y0 || y == ye || x == x0 || x == xe)
          exp_q.push_back((((y << 7) | x) << 8) | (col & 8'hFF));
  endtask

  task automatic wait_end(input int budget, input int need_done, input int done0);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !BUSY && (need_done == 0 || done_cnt != done0)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("timeout", int'(ok), 1);
    repeat (3) tick();
  endtask

  task automatic run_vec(input vec_t v);
    int w0;
    int d0;
    int go_cyc;
    w0 = wr_cnt;
    d0 = done_cnt;
    first_cyc = -1;
    done_cyc = -1;
    model(v.x0, v.y0, v.w, v.h, v.col, v.outl);
    io_wr(XY_AD, (v.y0 << 8) | v.x0);
    io_wr(WH_AD, (v.h << 8) | v.w);
    io_wr(GO_AD, (int'(v.outl) << 8) | v.col);
    go_cyc = cyc;
    wait_end(v.npix + 50, v.done, d0);
    check("pix_count", wr_cnt - w0, v.npix);
    check("done_count", done_cnt - d0, v.done);
    if (v.npix > 0) begin
      check("first_pixel_cycle", first_cyc - go_cyc, 1);
      check("last_pixel_cycle", last_cyc - go_cyc, v.npix);
    end
    if (v.done != 0) check("done_cycle", done_cyc - go_cyc, v.npix + 1);
    rd_stat("stat_after", v.stat);
    io_wr(STAT_AD, 0);
    rd_stat("stat_cleared", 0);
  endtask

  initial begin
    int w0;
    int d0;

    RESET_N    = 1'b0;
    IOBUS_ADDR = '0;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;

    vecs.push_back('{x0:10, y0:5,  w:3,   h:2,  col:8'hE0, outl:0, npix:6,    done:1, stat:0});
    vecs.push_back('{x0:78, y0:58, w:5,   h:5,  col:8'h1C, outl:0, npix:4,    done:1, stat:2});
    vecs.push_back('{x0:80, y0:0,  w:3,   h:3,  col:8'hFF, outl:0, npix:0,    done:0, stat:2});
    vecs.push_back('{x0:5,  y0:5,  w:0,   h:4,  col:8'h12, outl:0, npix:0,    done:1, stat:0});
    vecs.push_back('{x0:5,  y0:0,  w:2,   h:0,  col:8'h34, outl:0, npix:0,    done:1, stat:0});
    vecs.push_back('{x0:0,  y0:60, w:1,   h:1,  col:8'h56, outl:0, npix:0,    done:0, stat:2});
    vecs.push_back('{x0:79, y0:59, w:127, h:63, col:8'hAA, outl:0, npix:1,    done:1, stat:2});
    vecs.push_back('{x0:0,  y0:59, w:80,  h:3,  col:8'h55, outl:0, npix:80,   done:1, stat:2});
    vecs.push_back('{x0:40, y0:30, w:1,   h:4,  col:8'h07, outl:0, npix:4,    done:1, stat:0});
    vecs.push_back('{x0:0,  y0:0,  w:80,  h:60, col:8'h03, outl:0, npix:4800, done:1, stat:0});
`ifdef VGA_RECT_OUTLINE_EN
    vecs.push_back('{x0:0,  y0:0,  w:4,   h:4,  col:8'hC3, outl:1, npix:12,   done:1, stat:0});
    vecs.push_back('{x0:10, y0:10, w:1,   h:5,  col:8'h81, outl:1, npix:5,    done:1, stat:0});
    vecs.push_back('{x0:70, y0:50, w:20,  h:3,  col:8'h42, outl:1, npix:22,   done:1, stat:2});
`endif

    tick();
    tick();
    check("reset_fb_we", int'(FB_WE), 0);
    check("reset_fb_wa", int'(FB_WA), 0);
    check("reset_fb_wd", int'(FB_WD), 0);
    check("reset_busy", int'(BUSY), 0);
    check("reset_done", int'(DONE), 0);
    RESET_N = 1'b1;
    rd_stat("reset_stat", 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Second GO three cycles into an 8x8 fill is ignored and flags overrun.
    w0 = wr_cnt;
    d0 = done_cnt;
    model(20, 20, 8, 8, 8'h11, 1'b0);
    io_wr(XY_AD, (20 << 8) | 20);
    io_wr(WH_AD, (8 << 8) | 8);
    io_wr(GO_AD, 8'h11);
    tick();
    tick();
    io_wr(GO_AD, 8'h22);
    rd_stat("ovr_stat_busy", 5);
    wait_end(200, 1, d0);
    check("ovr_pix_count", wr_cnt - w0, 64);
    check("ovr_done_count", done_cnt - d0, 1);
    rd_stat("ovr_stat_after", 4);
    io_wr(STAT_AD, 32'hFFFF_FFFF);
    rd_stat("ovr_stat_cleared", 0);

    // Reset part-way through a 10x10 fill abandons it and clears sticky status.
    io_wr(XY_AD, 80);
    io_wr(GO_AD, 8'h01);
    rd_stat("pre_reset_clip", 2);
    model(0, 0, 10, 10, 8'h77, 1'b0);
    io_wr(XY_AD, 0);
    io_wr(WH_AD, (10 << 8) | 10);
    w0 = wr_cnt;
    io_wr(GO_AD, 8'h77);
    for (int i = 0; i < 200 && (wr_cnt - w0) < 20; i++) tick();
    check("pre_reset_pixels", wr_cnt - w0, 20);
    RESET_N = 1'b0;
    #1;
    check("rst_fb_we_now", int'(FB_WE), 0);
    check("rst_busy_now", int'(BUSY), 0);
    exp_q.delete();
    tick();
    tick();
    RESET_N = 1'b1;
    w0 = wr_cnt;
    d0 = done_cnt;
    repeat (5) tick();
    check("post_rst_writes", wr_cnt - w0, 0);
    check("post_rst_done", done_cnt - d0, 0);
    check("post_rst_busy", int'(BUSY), 0);
    check("post_rst_fb_wa", int'(FB_WA), 0);
    rd_stat("post_rst_stat", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
